// File: rtl/mod997_reduce_seq.sv
// Sequential modulo-MOD reducer: walks CHUNK-bit slices of a wide operand through
// an external per-slice residue LUT bank and accumulates the residues.
module mod997_reduce_seq #(
    parameter int W     = 400,
    parameter int CHUNK = 6,
    parameter int MOD   = 997,
    parameter int RW    = 10
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [W-1:0]                       in_data,
    output logic                               lut_en,
    output logic [$clog2((W+CHUNK-1)/CHUNK)-1:0] lut_sel,
    output logic [CHUNK-1:0]                   lut_addr,
    input  logic [RW-1:0]                      lut_data,
    input  logic                               clear,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [RW-1:0]                      out_data
);

    localparam int NCHUNK = (W + CHUNK - 1) / CHUNK;
    localparam int SW     = $clog2(NCHUNK);
    localparam int OPW    = NCHUNK * CHUNK;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [RW:0]   MOD_W     = (RW+1)'(MOD);
    localparam logic [SW-1:0] LAST_IDX  = SW'(NCHUNK - 1);

    logic [1:0]     state;
    logic [OPW-1:0] operand;
    logic [SW-1:0]  counter;
    logic [RW-1:0]  res_q;
    logic           res_live;
    logic [RW-1:0]  acc;
    logic [RW-1:0]  absorb_in;
    logic [RW-1:0]  acc_next;

    // Both acc and the residue are below MOD, so the sum is below 2*MOD and
    // a single conditional subtract restores the invariant.
    function automatic logic [RW-1:0] mod_add(input logic [RW-1:0] a, input logic [RW-1:0] b);
        logic [RW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= MOD_W)
            s = s - MOD_W;
        return s[RW-1:0];
    endfunction

    // Residue register holds nothing useful until the first lookup lands.
    assign absorb_in = res_live ? res_q : '0;
    assign acc_next  = mod_add(acc, absorb_in);

    assign in_ready = (state == IDLE);
    assign lut_en   = (state == ISSUE);
    assign lut_sel  = lut_en ? counter : '0;
    assign lut_addr = lut_en ? operand[int'(counter)*CHUNK +: CHUNK] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            operand   <= '0;
            counter   <= '0;
            res_q     <= '0;
            res_live  <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (clear && state != IDLE) begin
            state     <= IDLE;
            counter   <= '0;
            res_live  <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        operand  <= OPW'(in_data);
                        counter  <= '0;
                        acc      <= '0;
                        res_live <= 1'b0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    res_q    <= lut_data;
                    res_live <= 1'b1;
                    acc      <= acc_next;
                    counter  <= counter + 1'b1;
                    if (counter == LAST_IDX)
                        state <= DRAIN;
                end
                DRAIN: begin
                    acc       <= acc_next;
                    out_data  <= acc_next;
                    out_valid <= 1'b1;
                    res_live  <= 1'b0;
                    state     <= DONE;
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod997_reduce_seq.sv
// Self-checking bench for mod997_reduce_seq: behavioural LUT bank plus a
// bit-serial (Horner) reference for the full-operand residue.
module tb_mod997_reduce_seq;

    localparam int W     = 400;
    localparam int CHUNK = 6;
    localparam int MOD   = 997;
    localparam int RW    = 10;
    localparam int SW    = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          lut_en;
    logic [SW-1:0] lut_sel;
    logic [CHUNK-1:0] lut_addr;
    logic [RW-1:0] lut_data;
    logic          clear = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [RW-1:0] out_data;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mod997_reduce_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .lut_en(lut_en), .lut_sel(lut_sel), .lut_addr(lut_addr), .lut_data(lut_data),
        .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    function automatic int pow2mod(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = (r * 2) % MOD;
        return r;
    endfunction

    // LUT bank: (slice * 2^(CHUNK*k)) mod MOD
    always_comb lut_data = RW'((int'(lut_addr) * pow2mod(CHUNK * int'(lut_sel))) % MOD);

    function automatic int ref_mod(input logic [W-1:0] x);
        int r = 0;
        for (int i = W - 1; i >= 0; i--) r = (r * 2 + int'(x[i])) % MOD;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // One full job: accept, track the slice walk, stall the consumer, handshake.
    task automatic applyStimulus(input logic [W-1:0] op, input int stall, input int exp,
                                 input string tag, input bit check_seq);
        int seq_err = 0;
        int rdy_err = 0;
        int lat = -1;
        int stable_err = 0;
        logic [RW-1:0] held;
        @(negedge clk);
        checkOutput({tag, "_in_ready_idle"}, in_ready, 1);
        in_valid = 1'b1;
        in_data  = op;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        for (int n = 1; n <= 200; n++) begin
            if (n > 1) @(negedge clk);
            if (in_ready !== 1'b0) rdy_err++;
            if (out_valid === 1'b1) begin
                lat = n - 1;
                break;
            end
            if (n <= 67) begin
                if (lut_en !== 1'b1 || lut_sel !== SW'(n - 1)) seq_err++;
            end else if (lut_en !== 1'b0) seq_err++;
        end
        if (lat < 0) begin
            checkOutput({tag, "_timeout"}, 0, 1);
            return;
        end
        if (check_seq) begin
            checkOutput({tag, "_lut_seq"}, seq_err, 0);
            checkOutput({tag, "_latency"}, lat, 68);
        end
        checkOutput({tag, "_in_ready_busy"}, rdy_err, 0);
        checkOutput({tag, "_result"}, out_data, exp);
        held = out_data;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) stable_err++;
        end
        checkOutput({tag, "_stall_stable"}, stable_err, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "_released"}, {out_valid, in_ready}, 2'b01);
        checkOutput({tag, "_hold_data"}, out_data, exp);
    endtask

    task automatic waitSlice(input int k, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (lut_en === 1'b1 && lut_sel === SW'(k)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("slice_wait_timeout", 0, 1);
    endtask

    initial begin
        logic [W-1:0] op;
        bit ok;
        int seen;

        #12;
        checkOutput("reset_outputs", {in_ready, out_valid, out_data, lut_en, lut_sel, lut_addr}, {1'b1, 25'd0});
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(400'd0,     3, 0,   "op0",    1);
        applyStimulus(400'd997,   0, 0,   "op997",  0);
        applyStimulus(400'd1000,  1, 3,   "op1000", 0);
        applyStimulus(400'd996,   2, 996, "op996",  0);
        applyStimulus(400'd64740, 0, 932, "op64740", 1);
        applyStimulus(400'd1 << 64, 5, 961, "op2p64", 0);
        op = '1;
        applyStimulus(op, 4, ref_mod(op), "all_ones", 1);

        // Abort mid-walk; the aborted job must never produce a result.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 400'd12345;
        @(negedge clk);
        in_valid = 1'b0;
        waitSlice(30, ok);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checkOutput("clear_idle", {in_ready, out_valid, lut_en}, 3'b100);
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        checkOutput("clear_no_result", seen, 0);
        applyStimulus(400'd1000, 0, 3, "after_clear", 1);

        // Clear while a result is waiting drops it on the next edge.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 400'd996;
        @(negedge clk);
        in_valid = 1'b0;
        seen = 0;
        for (int n = 0; n < 200; n++) begin
            if (out_valid === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("done_reached", seen, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checkOutput("clear_in_done", {out_valid, in_ready}, 2'b01);

        // Asynchronous reset in the middle of the walk.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = '1;
        @(negedge clk);
        in_valid = 1'b0;
        waitSlice(40, ok);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_reset", {in_ready, out_valid, out_data, lut_en, lut_sel, lut_addr}, {1'b1, 25'd0});
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_release_ready", in_ready, 1);
        applyStimulus(400'd1 << 64, 0, 961, "after_reset", 1);

        for (int t = 0; t < 500; t++) begin
            op = '0;
            repeat (13) op = (op << 32) | W'($urandom);
            applyStimulus(op, $urandom_range(0, 20), ref_mod(op), $sformatf("rnd%0d", t), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
